// File: rtl/tm1638_refresh_sequencer.sv
// tm1638_refresh_sequencer
// Autonomous frame sequencer for the TM1638 LED & KEY board. It drives the
// activate/busy handshake of the SPI controller and repeats a fixed frame:
// auto-increment command, four 4-byte display writes taken from a 16-byte
// LED snapshot, brightness command, then a 4-byte key-scan read whose
// result is published on keys/keys_valid.
//
// Ports
//   clk, reset       : system clock, synchronous active-high reset
//   leds[127:0]      : display memory, byte i at [8i+7:8i] is grid address i
//   brightness[2:0]  : pulse-width setting 0..7
//   display_on       : display enable bit
//   refresh_req      : cut the inter-frame delay short
//   keys[7:0]        : raw key state (1 = pressed), keys_valid pulses on update
//   frame_count[31:0]: completed frames, wraps
//   fault            : sticky, set when busy never answers an activate
//   busy             : SPI controller busy
//   activate, in_cs  : transaction request and chip-select request
//   out_data[39:0]   : bytes to send, byte k at [8k+7:8k] (byte 0 first)
//   out_count, in_count : bytes to send / read in this transaction
//   in_data[31:0]    : bytes read back, byte k at [8k+7:8k]
module tm1638_refresh_sequencer #(
  parameter int unsigned POWER_UP_CYCLES = 32'd2_000_000,
  parameter int unsigned FRAME_DELAY     = 32'd460_000,
  parameter int unsigned BUSY_TIMEOUT    = 32'd1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] leds,
  input  logic [2:0]   brightness,
  input  logic         display_on,
  input  logic         refresh_req,
  output logic [7:0]   keys,
  output logic         keys_valid,
  output logic [31:0]  frame_count,
  output logic         fault,
  input  logic         busy,
  output logic         activate,
  output logic         in_cs,
  output logic [39:0]  out_data,
  output logic [2:0]   out_count,
  output logic [2:0]   in_count,
  input  logic [31:0]  in_data
);

  typedef enum logic [3:0] {
    S_POWER_UP = 4'd0,
    S_LATCH    = 4'd1,
    S_AUTO_INC = 4'd2,
    S_XMIT     = 4'd3,
    S_BRIGHT   = 4'd4,
    S_READ     = 4'd5,
    S_PUBLISH  = 4'd6,
    S_DELAY    = 4'd7,
    S_SEND     = 4'd8,
    S_AWAIT    = 4'd9
  } state_t;

  state_t        state_r, state_nxt_s;
  state_t        ret_r, ret_nxt_s;
  logic [31:0]   cnt_r, cnt_nxt_s;
  logic [1:0]    g_r, g_nxt_s;
  logic [127:0]  snap_leds_r, snap_leds_nxt_s;
  logic [2:0]    snap_bright_r, snap_bright_nxt_s;
  logic          snap_on_r, snap_on_nxt_s;
  // Command states stage their descriptor here; it only reaches the
  // outputs when S_SEND launches, so the outputs stay stable in between.
  logic [39:0]   stage_data_r, stage_data_nxt_s;
  logic [2:0]    stage_out_r, stage_out_nxt_s;
  logic [2:0]    stage_in_r, stage_in_nxt_s;
  logic          busy_seen_r, busy_seen_nxt_s;
  logic          activate_nxt_s, in_cs_nxt_s;
  logic [39:0]   out_data_nxt_s;
  logic [2:0]    out_count_nxt_s, in_count_nxt_s;
  logic [7:0]    keys_nxt_s;
  logic          keys_valid_nxt_s;
  logic [31:0]   frame_count_nxt_s;
  logic          fault_nxt_s;

  // Only the K-line bits 0 and 4 of each scan byte carry keys on this board.
  logic unused_in_data_s;
  assign unused_in_data_s = ^in_data;

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    ret_nxt_s         = ret_r;
    cnt_nxt_s         = cnt_r;
    g_nxt_s           = g_r;
    snap_leds_nxt_s   = snap_leds_r;
    snap_bright_nxt_s = snap_bright_r;
    snap_on_nxt_s     = snap_on_r;
    stage_data_nxt_s  = stage_data_r;
    stage_out_nxt_s   = stage_out_r;
    stage_in_nxt_s    = stage_in_r;
    busy_seen_nxt_s   = busy_seen_r;
    activate_nxt_s    = activate;
    in_cs_nxt_s       = in_cs;
    out_data_nxt_s    = out_data;
    out_count_nxt_s   = out_count;
    in_count_nxt_s    = in_count;
    keys_nxt_s        = keys;
    keys_valid_nxt_s  = 1'b0;
    frame_count_nxt_s = frame_count;
    fault_nxt_s       = fault;

    case (state_r)
      S_POWER_UP: begin
        if (cnt_r == 32'd0) begin
          state_nxt_s = S_LATCH;
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end
      S_LATCH: begin
        snap_leds_nxt_s   = leds;
        snap_bright_nxt_s = brightness;
        snap_on_nxt_s     = display_on;
        g_nxt_s           = 2'd0;
        state_nxt_s       = S_AUTO_INC;
      end
      S_AUTO_INC: begin
        stage_data_nxt_s = {32'h0000_0000, 8'h40};
        stage_out_nxt_s  = 3'd1;
        stage_in_nxt_s   = 3'd0;
        ret_nxt_s        = S_XMIT;
        state_nxt_s      = S_SEND;
      end
      S_XMIT: begin
        // Address byte first, then the four snapshot bytes of group g.
        stage_data_nxt_s = {snap_leds_r[{g_r, 5'b00000} +: 32],
                            8'hC0 + {4'b0000, g_r, 2'b00}};
        stage_out_nxt_s  = 3'd5;
        stage_in_nxt_s   = 3'd0;
        state_nxt_s      = S_SEND;
        if (g_r == 2'd3) begin
          ret_nxt_s = S_BRIGHT;
        end else begin
          ret_nxt_s = S_XMIT;
          g_nxt_s   = g_r + 2'd1;
        end
      end
      S_BRIGHT: begin
        stage_data_nxt_s = {32'h0000_0000, 4'h8, snap_on_r, snap_bright_r};
        stage_out_nxt_s  = 3'd1;
        stage_in_nxt_s   = 3'd0;
        ret_nxt_s        = S_READ;
        state_nxt_s      = S_SEND;
      end
      S_READ: begin
        stage_data_nxt_s = {32'h0000_0000, 8'h42};
        stage_out_nxt_s  = 3'd1;
        stage_in_nxt_s   = 3'd4;
        ret_nxt_s        = S_PUBLISH;
        state_nxt_s      = S_SEND;
      end
      S_PUBLISH: begin
        // Bit 0 of scan byte i is key i, bit 4 is key 4+i.
        keys_nxt_s        = {in_data[28], in_data[20], in_data[12], in_data[4],
                             in_data[24], in_data[16], in_data[8],  in_data[0]};
        keys_valid_nxt_s  = 1'b1;
        frame_count_nxt_s = frame_count + 32'd1;
        cnt_nxt_s         = FRAME_DELAY;
        state_nxt_s       = S_DELAY;
      end
      S_DELAY: begin
        if ((cnt_r == 32'd0) || refresh_req) begin
          state_nxt_s = S_LATCH;
        end else begin
          cnt_nxt_s = cnt_r - 32'd1;
        end
      end
      S_SEND: begin
        if (busy) begin
          activate_nxt_s = 1'b0;
        end else begin
          out_data_nxt_s  = stage_data_r;
          out_count_nxt_s = stage_out_r;
          in_count_nxt_s  = stage_in_r;
          in_cs_nxt_s     = 1'b1;
          activate_nxt_s  = 1'b1;
          busy_seen_nxt_s = 1'b0;
          cnt_nxt_s       = BUSY_TIMEOUT - 32'd1;
          state_nxt_s     = S_AWAIT;
        end
      end
      S_AWAIT: begin
        if (!busy_seen_r) begin
          if (busy) begin
            busy_seen_nxt_s = 1'b1;
            activate_nxt_s  = 1'b0;
          end else if (cnt_r == 32'd0) begin
            // Controller never answered: give up and re-initialise the board.
            activate_nxt_s = 1'b0;
            in_cs_nxt_s    = 1'b0;
            fault_nxt_s    = 1'b1;
            cnt_nxt_s      = POWER_UP_CYCLES;
            state_nxt_s    = S_POWER_UP;
          end else begin
            cnt_nxt_s = cnt_r - 32'd1;
          end
        end else begin
          if (!busy) begin
            in_cs_nxt_s = 1'b0;
            state_nxt_s = ret_r;
          end else begin
            state_nxt_s = S_AWAIT;
          end
        end
      end
      default: begin
        activate_nxt_s = 1'b0;
        in_cs_nxt_s    = 1'b0;
        cnt_nxt_s      = POWER_UP_CYCLES;
        state_nxt_s    = S_POWER_UP;
      end
    endcase
  end

  // State, datapath and registered outputs, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_POWER_UP;
      ret_r         <= S_LATCH;
      cnt_r         <= POWER_UP_CYCLES;
      g_r           <= 2'd0;
      snap_leds_r   <= 128'd0;
      snap_bright_r <= 3'd0;
      snap_on_r     <= 1'b0;
      stage_data_r  <= 40'd0;
      stage_out_r   <= 3'd0;
      stage_in_r    <= 3'd0;
      busy_seen_r   <= 1'b0;
      activate      <= 1'b0;
      in_cs         <= 1'b0;
      out_data      <= 40'd0;
      out_count     <= 3'd0;
      in_count      <= 3'd0;
      keys          <= 8'd0;
      keys_valid    <= 1'b0;
      frame_count   <= 32'd0;
      fault         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      ret_r         <= ret_nxt_s;
      cnt_r         <= cnt_nxt_s;
      g_r           <= g_nxt_s;
      snap_leds_r   <= snap_leds_nxt_s;
      snap_bright_r <= snap_bright_nxt_s;
      snap_on_r     <= snap_on_nxt_s;
      stage_data_r  <= stage_data_nxt_s;
      stage_out_r   <= stage_out_nxt_s;
      stage_in_r    <= stage_in_nxt_s;
      busy_seen_r   <= busy_seen_nxt_s;
      activate      <= activate_nxt_s;
      in_cs         <= in_cs_nxt_s;
      out_data      <= out_data_nxt_s;
      out_count     <= out_count_nxt_s;
      in_count      <= in_count_nxt_s;
      keys          <= keys_nxt_s;
      keys_valid    <= keys_valid_nxt_s;
      frame_count   <= frame_count_nxt_s;
      fault         <= fault_nxt_s;
    end
  end

endmodule

// File: tb/tb_tm1638_refresh_sequencer.sv
// Testbench for tm1638_refresh_sequencer: a busy model plays the SPI
// controller, the stimulus thread queues expected descriptors and key
// results, and a monitor checks each activate rise and keys_valid pulse.
module tb_tm1638_refresh_sequencer;

  localparam int P  = 20;
  localparam int FD = 30;
  localparam int BT = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] leds;
  logic [2:0]   brightness;
  logic         display_on;
  logic         refresh_req;
  logic [7:0]   keys;
  logic         keys_valid;
  logic [31:0]  frame_count;
  logic         fault;
  logic         busy;
  logic         activate;
  logic         in_cs;
  logic [39:0]  out_data;
  logic [2:0]   out_count;
  logic [2:0]   in_count;
  logic [31:0]  in_data;

  logic         busy_en;

  typedef struct packed {
    logic [39:0] data;
    logic [2:0]  oc;
    logic [2:0]  ic;
  } desc_t;

  typedef struct packed {
    logic [7:0]  k;
    logic [31:0] fc;
  } kexp_t;

  desc_t exp_desc_q[$];
  kexp_t exp_keys_q[$];
  desc_t mon_d;
  kexp_t mon_k;
  logic  prev_act = 1'b0;
  logic  prev_kv  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  tm1638_refresh_sequencer #(
    .POWER_UP_CYCLES(P),
    .FRAME_DELAY(FD),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .leds(leds),
    .brightness(brightness),
    .display_on(display_on),
    .refresh_req(refresh_req),
    .keys(keys),
    .keys_valid(keys_valid),
    .frame_count(frame_count),
    .fault(fault),
    .busy(busy),
    .activate(activate),
    .in_cs(in_cs),
    .out_data(out_data),
    .out_count(out_count),
    .in_count(in_count),
    .in_data(in_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_desc(input logic [39:0] data, input logic [2:0] oc, input logic [2:0] ic);
    desc_t d;
    d.data = data;
    d.oc   = oc;
    d.ic   = ic;
    exp_desc_q.push_back(d);
  endtask

  task automatic push_frame(input logic [39:0] x0, input logic [39:0] x1,
                            input logic [39:0] x2, input logic [39:0] x3,
                            input logic [7:0] br);
    push_desc(40'h00_0000_0040, 3'd1, 3'd0);
    push_desc(x0, 3'd5, 3'd0);
    push_desc(x1, 3'd5, 3'd0);
    push_desc(x2, 3'd5, 3'd0);
    push_desc(x3, 3'd5, 3'd0);
    push_desc({32'h0000_0000, br}, 3'd1, 3'd0);
    push_desc(40'h00_0000_0042, 3'd1, 3'd4);
  endtask

  task automatic push_keys(input logic [7:0] k, input logic [31:0] fc);
    kexp_t e;
    e.k  = k;
    e.fc = fc;
    exp_keys_q.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_activate"}, 64'(activate), 64'd0);
    check({tag, "_in_cs"}, 64'(in_cs), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
    check({tag, "_in_count"}, 64'(in_count), 64'd0);
    check({tag, "_keys"}, 64'(keys), 64'd0);
    check({tag, "_keys_valid"}, 64'(keys_valid), 64'd0);
    check({tag, "_frame_count"}, 64'(frame_count), 64'd0);
    check({tag, "_fault"}, 64'(fault), 64'd0);
  endtask

  // Counts negedges until activate is seen high; pulses refresh_req at step refresh_at.
  task automatic measure_gap(input int refresh_at, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (refresh_at != 0) refresh_req = (n == refresh_at);
    end while (!activate && n < 5000);
    refresh_req = 1'b0;
  endtask

  task automatic wait_kv(input string name);
    int n = 0;
    while (!keys_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(keys_valid), 64'd1);
  endtask

  task automatic wait_rise(input string name);
    int n = 0;
    while (activate && n < 3000) begin
      @(negedge clk);
      n++;
    end
    while (!activate && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(activate), 64'd1);
  endtask

  // Busy model: raises busy two cycles after activate, holds it ten cycles.
  initial begin : busy_model
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy_en && activate) begin
        @(negedge clk);
        busy = 1'b1;
        repeat (10) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Monitor: checks every new transaction and every key publication.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (activate && !prev_act) begin
        if (exp_desc_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_activate: got out_data 0x%0h, expected no transaction", out_data);
        end else begin
          mon_d = exp_desc_q.pop_front();
          check("desc_out_data", 64'(out_data), 64'(mon_d.data));
          check("desc_out_count", 64'(out_count), 64'(mon_d.oc));
          check("desc_in_count", 64'(in_count), 64'(mon_d.ic));
          check("desc_in_cs", 64'(in_cs), 64'd1);
        end
      end
      if (prev_kv) check("keys_valid_one_cycle", 64'(keys_valid), 64'd0);
      if (keys_valid && !prev_kv) begin
        if (exp_keys_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_keys_valid: got keys 0x%0h, expected no publication", keys);
        end else begin
          mon_k = exp_keys_q.pop_front();
          check("keys_value", 64'(keys), 64'(mon_k.k));
          check("frame_count", 64'(frame_count), 64'(mon_k.fc));
        end
      end
      prev_act = activate;
      prev_kv  = keys_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int c;
    reset       = 1'b1;
    leds        = 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F;
    brightness  = 3'd7;
    display_on  = 1'b1;
    refresh_req = 1'b0;
    in_data     = 32'h0110_0011;
    busy_en     = 1'b1;

    push_frame(40'h3C2D1E0FC0, 40'h78695A4BC4, 40'hB4A59687C8, 40'hF0E1D2C3CC, 8'h8F);
    push_keys(8'h59, 32'd1);

    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    measure_gap(0, n);
    check("first_activate_latency", 64'(n), 64'(P + 4));

    // After the snapshot of frame 1: new byte 5, brightness 3, display off.
    leds[47:40] = 8'h55;
    brightness  = 3'd3;
    display_on  = 1'b0;
    push_frame(40'h3C2D1E0FC0, 40'h7869554BC4, 40'hB4A59687C8, 40'hF0E1D2C3CC, 8'h83);
    push_frame(40'h3C2D1E0FC0, 40'h7869554BC4, 40'hB4A59687C8, 40'hF0E1D2C3CC, 8'h83);
    push_keys(8'h36, 32'd2);
    push_keys(8'h36, 32'd3);

    wait_kv("frame1_keys_valid");
    in_data = 32'h0001_1110;
    measure_gap(0, n);
    check("frame_gap", 64'(n), 64'(FD + 4));

    // refresh_req held across the display writes must not shorten the next delay.
    wait_rise("frame2_xmit_start");
    refresh_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_rise("frame2_xmit_next");
    refresh_req = 1'b0;

    wait_kv("frame2_keys_valid");
    measure_gap(0, n);
    check("gap_after_xmit_refresh", 64'(n), 64'(FD + 4));

    wait_kv("frame3_keys_valid");
    busy_en = 1'b0;
    push_desc(40'h00_0000_0040, 3'd1, 3'd0);
    push_desc(40'h00_0000_0040, 3'd1, 3'd0);
    measure_gap(5, n);
    check("refresh_in_delay_gap", 64'(n), 64'd9);

    c = 1;
    while (c < 5000) begin
      @(negedge clk);
      if (activate) c++;
      else break;
    end
    check("busy_timeout_len", 64'(c), 64'(BT));
    check("timeout_fault", 64'(fault), 64'd1);
    check("timeout_in_cs", 64'(in_cs), 64'd0);

    busy_en = 1'b1;
    measure_gap(0, n);
    check("restart_after_fault", 64'(n), 64'(P + 4));
    check("fault_sticky", 64'(fault), 64'd1);

    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!busy && n < 20);
    check("busy_answer_seen", 64'(busy), 64'd1);
    @(negedge clk);
    check("activate_drops_on_busy", 64'(activate), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("desc_queue_drained", 64'(exp_desc_q.size()), 64'd0);
    check("keys_queue_drained", 64'(exp_keys_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tm1638_refresh_sequencer.md
# tm1638_refresh_sequencer

Autonomous frame sequencer for the LED & KEY (TM1638) board. It owns the activate/busy handshake to `spi_controller_ht16d35a` and repeats a fixed frame: auto-increment command, four 4-byte display writes from a 16-byte LED memory, brightness command, then a 4-byte key-scan read. It publishes debounced-free raw key state and sits between the board top level and the SPI controller, replacing the hand-written top-level state machine.

## Interface
- `POWER_UP_CYCLES`, 2_000_000, idle cycles after reset before the first frame (40 ms at 50 MHz)
- `FRAME_DELAY`, 460_000, idle cycles between frames
- `BUSY_TIMEOUT`, 1024, max cycles after `activate` before `busy` must be seen
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: one clock; reset is synchronous and active-high
- `leds` in [16]x8: TM1638 display memory, byte i is grid address i
- `brightness` in 3: pulse-width setting 0..7
- `display_on` in 1: display enable bit
- `refresh_req` in 1: skip the remaining inter-frame delay
- `keys` out 8: key state, 1 = pressed
- `keys_valid` out 1: one-cycle pulse when `keys` updates
- `frame_count` out 32: completed frames, wraps
- `fault` out 1: sticky, set on busy timeout
- `busy` in 1: SPI controller busy
- `activate` out 1: SPI transaction request
- `in_cs` out 1: chip select request (active high)
- `out_data` out [5]x8, `out_count` out 3, `in_count` out 3: transaction descriptor
- `in_data` in [4]x8: bytes read by the SPI controller

## Operation
- States: S_POWER_UP, S_LATCH, S_AUTO_INC, S_XMIT, S_BRIGHT, S_READ, S_PUBLISH, S_DELAY, plus subroutine S_SEND, S_AWAIT (return state held in a register).
- S_POWER_UP: down-counter loaded with POWER_UP_CYCLES; at 0 go S_LATCH.
- S_LATCH: snapshot `leds`, `brightness`, `display_on` into internal registers; all frame bytes come from the snapshot. Clear group counter g.
- S_AUTO_INC: descriptor {0x40}, out_count 1, in_count 0; return S_XMIT.
- S_XMIT: descriptor {0xC0 + 4g, snap[4g], snap[4g+1], snap[4g+2], snap[4g+3]}, out_count 5, in_count 0. g<3: g++ and return S_XMIT; g==3: return S_BRIGHT.
- S_BRIGHT: {0x80 | display_on<<3 | brightness}, out_count 1; return S_READ.
- S_READ: {0x42}, out_count 1, in_count 4; return S_PUBLISH.
- S_PUBLISH: keys[i] = in_data[i][0], keys[4+i] = in_data[i][4] for i=0..3; pulse `keys_valid`; frame_count++; load counter with FRAME_DELAY; go S_DELAY.
- S_DELAY: count down; at 0, or `refresh_req` high, go S_LATCH. `refresh_req` ignored in all other states.
- S_SEND: while `busy` high, hold `activate` 0. When `busy` low, drive the descriptor, `in_cs`=1, `activate`=1, clear busy_seen, go S_AWAIT.
- S_AWAIT: busy && !busy_seen: set busy_seen, `activate`=0. busy_seen && !busy: go return state. If busy is not seen within BUSY_TIMEOUT cycles: `activate`=0, set `fault`, go S_POWER_UP (full re-init).
- `out_data`/counts hold their last value between transactions; unused out_data bytes are 0.

## Timing
- Reset values: activate 0, in_cs 0, out_data all 0, out_count 0, in_count 0, keys 0, keys_valid 0, frame_count 0, fault 0, state S_POWER_UP, counter POWER_UP_CYCLES.
- Reset mid-transaction: all of the above on the next edge, including during busy; the SPI controller is reset from the same signal.
- First `activate` rises POWER_UP_CYCLES+4 cycles after reset deasserts (POWER_UP_CYCLES+1 to leave S_POWER_UP, +1 S_LATCH, +1 S_AUTO_INC, +1 S_SEND), assuming busy low.
- `activate` is high from the S_SEND edge until the first cycle busy is sampled high; never high while in any state other than S_AWAIT.
- Descriptor stable from the S_SEND edge until the next S_SEND.
- Exactly 7 transactions per frame, in order 0x40, 0xC0, 0xC4, 0xC8, 0xCC, 0x8x, 0x42.
- frame_count 0xFFFF_FFFF + 1 wraps to 0.

## Test plan
- Reset, busy model answers 2 cycles after activate for 10 cycles: first activate at POWER_UP_CYCLES+4; byte sequence 0x40; 0xC0+leds[0..3]; 0xC4..; 0xCC+leds[12..15]; 0x8F (brightness 7, on); 0x42 with in_count 4.
- in_data = {0x11, 0x00, 0x10, 0x01} -> keys = 0x59 (bits 0,3,4,6), keys_valid one cycle, frame_count 1.
- Change `leds[5]` mid-frame after S_LATCH -> current frame sends old value, next frame sends new.
- `refresh_req` pulse in S_DELAY -> S_LATCH next cycle; pulse during S_XMIT -> no effect on delay length.
- Busy model never asserts -> activate drops after BUSY_TIMEOUT, fault=1 and stays 1, sequencer restarts power-up.
- Assert reset while busy high in S_AWAIT -> all outputs at reset values next cycle, fault cleared.
